// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-addressed 64-bit data memory: slices and extends
// loads, builds byte/half/word stores as read-modify-write, and rejects faulting requests.
module load_store_unit #(
   parameter  int DATA_WIDTH_POW = 6,
   parameter  int ADDR_WIDTH_POW = 6,
   parameter  int MEM_DEPTH_POW  = 12,
   localparam int DW             = 2 ** DATA_WIDTH_POW,
   localparam int AW             = 2 ** ADDR_WIDTH_POW
) (
   input  logic          clk_in,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_store,
   input  logic [2:0]    req_funct3,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_write,
   output logic          mem_read,
   input  logic [DW-1:0] mem_rdata,
   output logic          resp_valid,
   output logic [DW-1:0] resp_data,
   output logic          resp_fault,
   output logic [1:0]    resp_cause
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_READ, S_WRITE, S_RESP} state_t;
   typedef enum logic [1:0] {
      CAUSE_NONE       = 2'b00,
      CAUSE_MISALIGNED = 2'b01,
      CAUSE_ILLEGAL    = 2'b10,
      CAUSE_RANGE      = 2'b11
   } cause_t;

   state_t        state_q, state_d;
   cause_t        cause_q, cause_in;
   logic [2:0]    funct3_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;     // store data, replaced by the merged word after RMW_READ
   logic [DW-1:0] result_q;
   logic          accept;
   logic          illegal, misaligned, out_of_range;
   logic [5:0]    lane_shift;
   logic [DW-1:0] shifted, load_val, lane_mask, merged;
   logic          sign_ok;

   assign req_ready = (state_q == S_IDLE) && !reset;
   assign accept    = req_valid && req_ready;

   // Request classification, evaluated on the live request so the fault is known at accept.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      misaligned = 1'b0;
      case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         2'b11:   misaligned = |req_addr[2:0];
         default: misaligned = 1'b0;
      endcase
      illegal      = req_store ? req_funct3[2] : (req_funct3 == 3'b111);
      out_of_range = |req_addr[AW-1:MEM_DEPTH_POW+3];
      if (illegal)         cause_in = CAUSE_ILLEGAL;
      else if (misaligned) cause_in = CAUSE_MISALIGNED;
      else if (out_of_range) cause_in = CAUSE_RANGE;
      else                 cause_in = CAUSE_NONE;
   end

   // Lane handling for the latched request against the word coming back from memory.
   always_comb begin
      lane_shift = {addr_q[2:0], 3'b000};
      shifted    = mem_rdata >> lane_shift;
      sign_ok    = ~funct3_q[2];
      lane_mask  = '0;
      case (funct3_q[1:0])
         2'b00: begin
            load_val        = {{(DW-8){sign_ok & shifted[7]}}, shifted[7:0]};
            lane_mask[7:0]  = '1;
         end
         2'b01: begin
            load_val        = {{(DW-16){sign_ok & shifted[15]}}, shifted[15:0]};
            lane_mask[15:0] = '1;
         end
         2'b10: begin
            load_val        = {{(DW-32){sign_ok & shifted[31]}}, shifted[31:0]};
            lane_mask[31:0] = '1;
         end
         default: begin
            load_val  = shifted;
            lane_mask = '1;
         end
      endcase
      merged = (mem_rdata & ~(lane_mask << lane_shift)) |
               ((wdata_q << lane_shift) & (lane_mask << lane_shift));
   end

   always_comb begin
      state_d    = state_q;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      resp_valid = 1'b0;
      resp_data  = '0;
      resp_fault = 1'b0;
      resp_cause = 2'b00;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (cause_in != CAUSE_NONE)    state_d = S_RESP;
               else if (!req_store)           state_d = S_LOAD;
               else if (req_funct3[1:0] == 2'b11) state_d = S_WRITE;
               else                           state_d = S_RMW_READ;
            end
         end
         S_LOAD: begin
            mem_read = 1'b1;
            mem_addr = {addr_q[AW-1:3], 3'b000};
            state_d  = S_RESP;
         end
         S_RMW_READ: begin
            mem_read = 1'b1;
            mem_addr = {addr_q[AW-1:3], 3'b000};
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            mem_write = 1'b1;
            mem_addr  = {addr_q[AW-1:3], 3'b000};
            mem_wdata = wdata_q;
            state_d   = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_data  = result_q;
            resp_fault = (cause_q != CAUSE_NONE);
            resp_cause = cause_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Reset kills the in-flight request immediately: no write or response in the reset cycle.
      if (reset) begin
         mem_addr   = '0;
         mem_wdata  = '0;
         mem_write  = 1'b0;
         mem_read   = 1'b0;
         resp_valid = 1'b0;
         resp_data  = '0;
         resp_fault = 1'b0;
         resp_cause = 2'b00;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cause_q  <= CAUSE_NONE;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            cause_q  <= cause_in;
            result_q <= '0;
         end
         if (state_q == S_LOAD)     result_q <= load_val;
         if (state_q == S_RMW_READ) wdata_q  <= merged;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized traffic
// against a byte-level reference model and a bench-owned data memory.
module tb_load_store_unit;

   localparam int MEM_WORDS  = 4096;
   localparam int RAND_WORDS = 64;

   logic        clk_in     = 1'b0;
   logic        reset      = 1'b1;
   logic        req_valid  = 1'b0;
   logic        req_store  = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [63:0] req_addr   = '0;
   logic [63:0] req_wdata  = '0;
   logic        req_ready;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_write, mem_read;
   logic        resp_valid;
   logic [63:0] resp_data;
   logic        resp_fault;
   logic [1:0]  resp_cause;

   logic [63:0] mem     [MEM_WORDS];
   logic [63:0] ref_mem [MEM_WORDS];
   logic        pre_we  = 1'b0;
   logic [11:0] pre_idx = '0;
   logic [63:0] pre_val = '0;

   int n_vec = 0, n_err = 0, both_cnt = 0, addr_bad = 0;

   load_store_unit #(.MEM_DEPTH_POW(12)) dut (
      .clk_in(clk_in), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_read(mem_read), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
      .resp_cause(resp_cause)
   );

   always #5 clk_in = ~clk_in;

   assign mem_rdata = mem[mem_addr[14:3]];
   always @(posedge clk_in) begin
      if (mem_write) mem[mem_addr[14:3]] <= mem_wdata;
      if (pre_we)    mem[pre_idx] <= pre_val;
   end

   always @(negedge clk_in) begin
      if (mem_read && mem_write) both_cnt++;
      if (mem_addr[63:15] != 0 || mem_addr[2:0] != 0) addr_bad++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic preload(input int idx, input logic [63:0] v);
      @(negedge clk_in);
      pre_we = 1'b1; pre_idx = 12'(idx); pre_val = v; ref_mem[idx] = v;
      @(posedge clk_in);
      #1 pre_we = 1'b0;
   endtask

   // Reference model: byte-by-byte view of the memory and the access rules.
   task automatic ref_exec(input logic st, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, output logic [63:0] e_data,
                           output logic [1:0] e_cause, output int e_lat);
      int          nbytes;
      int          off;
      logic [63:0] widx;
      logic [63:0] w;
      nbytes  = 1 << f3[1:0];
      off     = int'(a[2:0]);
      widx    = a >> 3;
      e_data  = '0;
      e_cause = 2'd0;
      if (st ? f3[2] : (f3 == 3'b111)) e_cause = 2'd2;
      else if ((a % 64'(nbytes)) != 0) e_cause = 2'd1;
      else if (widx >= 64'(MEM_WORDS)) e_cause = 2'd3;
      if (e_cause != 2'd0) begin
         e_lat = 1;
         return;
      end
      w = ref_mem[widx[11:0]];
      if (!st) begin
         for (int i = 0; i < nbytes; i++) e_data[8*i +: 8] = w[8*(off+i) +: 8];
         if (!f3[2] && nbytes < 8 && e_data[8*nbytes-1])
            for (int i = nbytes; i < 8; i++) e_data[8*i +: 8] = 8'hFF;
         e_lat = 2;
      end else begin
         for (int i = 0; i < nbytes; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
         ref_mem[widx[11:0]] = w;
         e_lat = (nbytes == 8) ? 2 : 3;
      end
   endtask

   // Presents one request in IDLE and observes it until its response (10-cycle bound).
   task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, output int lat, output logic [63:0] rd,
                         output logic flt, output logic [1:0] cs, output int n_rd,
                         output int n_wr, output int rd_cyc, output int wr_cyc,
                         output logic [63:0] wr_addr, output logic [63:0] wr_data);
      lat = -1; rd = '0; flt = 1'b0; cs = 2'd0; n_rd = 0; n_wr = 0;
      rd_cyc = -1; wr_cyc = -1; wr_addr = '0; wr_data = '0;
      @(negedge clk_in);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk_in);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk_in);
         if (mem_read) begin
            n_rd++;
            if (rd_cyc < 0) rd_cyc = c;
         end
         if (mem_write) begin
            n_wr++; wr_cyc = c; wr_addr = mem_addr; wr_data = mem_wdata;
         end
         if (resp_valid) begin
            lat = c; rd = resp_data; flt = resp_fault; cs = resp_cause;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int resp_seen;
      resp_seen = 0;
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b011; req_addr = 64'h40;
      repeat (3) @(negedge clk_in);
      n_vec++;
      if ({resp_valid, resp_data, resp_fault, resp_cause, mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: resp_valid=%b resp_data=%h fault=%b cause=%b rd=%b wr=%b addr=%h wdata=%h, required all zero",
                  resp_valid, resp_data, resp_fault, resp_cause, mem_read, mem_write, mem_addr, mem_wdata);
      end
      @(posedge clk_in);
      #1 reset = 1'b0; req_valid = 1'b0;
      @(negedge clk_in);
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
      end
      repeat (3) begin
         @(negedge clk_in);
         if (resp_valid) resp_seen++;
      end
      n_vec++;
      if (resp_seen !== 0) begin
         n_err++; $display("FAIL reset_no_accept: %0d responses after reset, required 0", resp_seen);
      end
   endtask

   task automatic test_loads();
      logic [63:0] addrs [3] = '{64'h13, 64'h16, 64'h16};
      logic [2:0]  f3s   [3] = '{3'b000, 3'b001, 3'b101};
      logic [63:0] exps  [3] = '{64'h0000000000000044, 64'hFFFFFFFFFFFF8877, 64'h0000000000008877};
      logic [63:0] ed, rd, wa, wdt;
      logic [1:0]  ec, cs;
      logic        flt;
      int          el, lat, nr, nw, rc, wc;
      preload(2, 64'h8877665544332211);
      for (int i = 0; i < 3; i++) begin
         ref_exec(1'b0, f3s[i], addrs[i], '0, ed, ec, el);
         do_req(1'b0, f3s[i], addrs[i], '0, lat, rd, flt, cs, nr, nw, rc, wc, wa, wdt);
         n_vec++;
         if (lat !== 2) begin n_err++; $display("FAIL load%0d_latency: got %0d, required 2", i, lat); end
         n_vec++;
         if (rd !== exps[i] || flt !== 1'b0) begin
            n_err++; $display("FAIL load%0d_data: got %h fault=%b, required %h fault=0", i, rd, flt, exps[i]);
         end
      end
   endtask

   task automatic test_store_rmw();
      logic [63:0] ed, rd, wa, wdt;
      logic [1:0]  ec, cs;
      logic        flt;
      int          el, lat, nr, nw, rc, wc;
      preload(4, 64'h1111111111111111);
      ref_exec(1'b1, 3'b000, 64'h22, 64'hAB, ed, ec, el);
      do_req(1'b1, 3'b000, 64'h22, 64'hAB, lat, rd, flt, cs, nr, nw, rc, wc, wa, wdt);
      n_vec++;
      if (rc !== 1 || wc !== 2) begin
         n_err++; $display("FAIL sb_timing: read at +%0d write at +%0d, required +1 and +2", rc, wc);
      end
      n_vec++;
      if (wa !== 64'h20 || wdt !== 64'h1111111111AB1111) begin
         n_err++; $display("FAIL sb_write: addr=%h data=%h, required 20 / 1111111111ab1111", wa, wdt);
      end
      n_vec++;
      if (lat !== 3 || flt !== 1'b0) begin
         n_err++; $display("FAIL sb_resp: latency %0d fault %b, required 3 / 0", lat, flt);
      end
      n_vec++;
      if (mem[4] !== 64'h1111111111AB1111) begin
         n_err++; $display("FAIL sb_mem: word 0x20 = %h, required 1111111111ab1111", mem[4]);
      end
   endtask

   task automatic test_store_d();
      logic [63:0] ed, rd, wa, wdt;
      logic [1:0]  ec, cs;
      logic        flt;
      int          el, lat, nr, nw, rc, wc;
      ref_exec(1'b1, 3'b011, 64'h28, 64'hDEADBEEFCAFEF00D, ed, ec, el);
      do_req(1'b1, 3'b011, 64'h28, 64'hDEADBEEFCAFEF00D, lat, rd, flt, cs, nr, nw, rc, wc, wa, wdt);
      n_vec++;
      if (wc !== 1 || nr !== 0 || wdt !== 64'hDEADBEEFCAFEF00D) begin
         n_err++; $display("FAIL sd_write: write at +%0d reads %0d data %h, required +1 / 0 / deadbeefcafef00d", wc, nr, wdt);
      end
      n_vec++;
      if (lat !== 2) begin n_err++; $display("FAIL sd_latency: got %0d, required 2", lat); end
      ref_exec(1'b0, 3'b011, 64'h28, '0, ed, ec, el);
      do_req(1'b0, 3'b011, 64'h28, '0, lat, rd, flt, cs, nr, nw, rc, wc, wa, wdt);
      n_vec++;
      if (rd !== 64'hDEADBEEFCAFEF00D || lat !== 2) begin
         n_err++; $display("FAIL ld_after_sd: got %h latency %0d, required deadbeefcafef00d / 2", rd, lat);
      end
   endtask

   task automatic test_faults();
      logic        sts   [3] = '{1'b0, 1'b1, 1'b0};
      logic [2:0]  f3s   [3] = '{3'b010, 3'b100, 3'b011};
      logic [63:0] addrs [3] = '{64'h1, 64'h40, 64'h8000};
      logic [1:0]  causes[3] = '{2'b01, 2'b10, 2'b11};
      logic [63:0] ed, rd, wa, wdt;
      logic [1:0]  ec, cs;
      logic        flt;
      int          el, lat, nr, nw, rc, wc;
      for (int i = 0; i < 3; i++) begin
         ref_exec(sts[i], f3s[i], addrs[i], 64'h55, ed, ec, el);
         do_req(sts[i], f3s[i], addrs[i], 64'h55, lat, rd, flt, cs, nr, nw, rc, wc, wa, wdt);
         n_vec++;
         if (lat !== 1 || flt !== 1'b1 || cs !== causes[i] || rd !== '0) begin
            n_err++;
            $display("FAIL fault%0d_resp: latency %0d fault %b cause %b data %h, required 1 / 1 / %b / 0",
                     i, lat, flt, cs, rd, causes[i]);
         end
         n_vec++;
         if (nr !== 0 || nw !== 0) begin
            n_err++; $display("FAIL fault%0d_mem: %0d reads %0d writes, required none", i, nr, nw);
         end
      end
   endtask

   task automatic test_reset_mid();
      int wr_seen, resp_seen;
      wr_seen = 0; resp_seen = 0;
      preload(6, 64'h0123456789ABCDEF);
      @(negedge clk_in);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001; req_addr = 64'h30; req_wdata = 64'h5555;
      @(posedge clk_in);
      #1 req_valid = 1'b0;
      @(negedge clk_in);
      n_vec++;
      if (mem_read !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_rmw_read: mem_read=%b at +1, required 1", mem_read);
      end
      reset = 1'b1;
      #1;
      if (mem_write) wr_seen++;
      if (resp_valid) resp_seen++;
      @(posedge clk_in);
      #1 reset = 1'b0;
      @(negedge clk_in);
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_ready: req_ready=%b after reset, required 1", req_ready);
      end
      for (int c = 0; c < 6; c++) begin
         if (mem_write) wr_seen++;
         if (resp_valid) resp_seen++;
         @(negedge clk_in);
      end
      n_vec++;
      if (wr_seen !== 0 || resp_seen !== 0) begin
         n_err++; $display("FAIL rst_mid_dropped: %0d writes %0d responses, required 0 / 0", wr_seen, resp_seen);
      end
      n_vec++;
      if (mem[6] !== 64'h0123456789ABCDEF) begin
         n_err++; $display("FAIL rst_mid_mem: word 0x30 = %h, required 0123456789abcdef", mem[6]);
      end
   endtask

   task automatic test_back_to_back();
      localparam int N = 6;
      logic [63:0] q[$];
      logic [63:0] ed;
      logic [1:0]  ec;
      int          el, acc, resp_cnt, last_acc, last_resp;
      logic        rdy;
      acc = 0; resp_cnt = 0; last_acc = -1; last_resp = -1;
      @(negedge clk_in);
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b011;
      req_addr = 64'($urandom_range(0, RAND_WORDS - 1)) << 3;
      for (int cyc = 0; cyc < 40 && resp_cnt < N; cyc++) begin
         if (resp_valid) begin
            n_vec++;
            if (q.size() == 0) begin
               n_err++; $display("FAIL b2b_spurious: response at cycle %0d with nothing outstanding", cyc);
            end else begin
               ed = q.pop_front();
               if (resp_data !== ed) begin
                  n_err++; $display("FAIL b2b_data: cycle %0d got %h, required %h", cyc, resp_data, ed);
               end
            end
            n_vec++;
            if (req_ready !== 1'b0) begin
               n_err++; $display("FAIL b2b_ready_in_resp: req_ready=%b during response, required 0", req_ready);
            end
            if (last_resp >= 0) begin
               n_vec++;
               if (cyc - last_resp !== 3) begin
                  n_err++; $display("FAIL b2b_resp_spacing: %0d cycles, required 3", cyc - last_resp);
               end
            end
            last_resp = cyc;
            resp_cnt++;
         end
         rdy = req_ready;
         @(posedge clk_in);
         if (rdy && req_valid) begin
            ref_exec(1'b0, 3'b011, req_addr, '0, ed, ec, el);
            q.push_back(ed);
            acc++;
            if (last_acc >= 0) begin
               n_vec++;
               if (cyc - last_acc !== 3) begin
                  n_err++; $display("FAIL b2b_accept_spacing: %0d cycles, required 3", cyc - last_acc);
               end
            end
            last_acc = cyc;
            #1;
            if (acc == N) req_valid = 1'b0;
            else req_addr = 64'($urandom_range(0, RAND_WORDS - 1)) << 3;
         end
         @(negedge clk_in);
      end
      req_valid = 1'b0;
      n_vec++;
      if (acc !== N || resp_cnt !== N) begin
         n_err++; $display("FAIL b2b_count: %0d accepts %0d responses, required %0d each", acc, resp_cnt, N);
      end
   endtask

   task automatic test_random();
      logic        st;
      logic [2:0]  f3;
      logic [63:0] a, wd, ed, rd, wa, wdt;
      logic [1:0]  ec, cs;
      logic        flt;
      int          el, lat, nr, nw, rc, wc, sel, off, e_rd, e_wr;
      for (int it = 0; it < 200; it++) begin
         st  = 1'($urandom_range(0, 1));
         f3  = 3'($urandom_range(0, 7));
         sel = int'($urandom_range(0, 9));
         off = int'($urandom_range(0, 7));
         if (sel < 6) off = off & ~((1 << f3[1:0]) - 1);
         if (sel == 0) a = (64'($urandom_range(MEM_WORDS, 100000)) << 3) | 64'(off);
         else          a = (64'($urandom_range(0, RAND_WORDS - 1)) << 3) | 64'(off);
         wd = {$urandom, $urandom};
         ref_exec(st, f3, a, wd, ed, ec, el);
         do_req(st, f3, a, wd, lat, rd, flt, cs, nr, nw, rc, wc, wa, wdt);
         e_rd = (ec == 2'd0 && (!st || f3[1:0] != 2'b11)) ? 1 : 0;
         e_wr = (ec == 2'd0 && st) ? 1 : 0;
         n_vec++;
         if (lat !== el || rd !== ed || flt !== (ec != 2'd0) || cs !== ec) begin
            n_err++;
            $display("FAIL rand%0d_resp st=%b f3=%b addr=%h: latency %0d data %h fault %b cause %b, required %0d / %h / %b / %b",
                     it, st, f3, a, lat, rd, flt, cs, el, ed, (ec != 2'd0), ec);
         end
         n_vec++;
         if (nr !== e_rd || nw !== e_wr) begin
            n_err++;
            $display("FAIL rand%0d_mem st=%b f3=%b addr=%h: %0d reads %0d writes, required %0d / %0d",
                     it, st, f3, a, nr, nw, e_rd, e_wr);
         end
      end
      for (int w = 0; w < RAND_WORDS; w++) begin
         n_vec++;
         if (mem[w] !== ref_mem[w]) begin
            n_err++; $display("FAIL mem_word%0d: memory holds %h, required %h", w, mem[w], ref_mem[w]);
         end
      end
   endtask

   initial begin
      test_reset();
      for (int w = 0; w < RAND_WORDS; w++) preload(w, {$urandom, $urandom});
      test_loads();
      test_store_rmw();
      test_store_d();
      test_faults();
      test_reset_mid();
      test_back_to_back();
      test_random();
      n_vec++;
      if (both_cnt !== 0) begin
         n_err++; $display("FAIL read_write_overlap: %0d cycles with both enables, required 0", both_cnt);
      end
      n_vec++;
      if (addr_bad !== 0) begin
         n_err++; $display("FAIL mem_addr_shape: %0d cycles with unaligned/out-of-range address, required 0", addr_bad);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the data memory. Takes load/store requests from the execute stage and issues word-aligned 64-bit accesses to the memory.
- The data memory is word-addressable only, with no byte enables. This block therefore builds byte/half/word stores as a read-modify-write sequence, and slices and extends load data.
- Flags misaligned, illegal-size and out-of-range accesses and never forwards them to memory.
- Returns one response pulse per accepted request.

Parameters:
- DATA_WIDTH_POW, 6, log2 of data width; only 6 (64-bit) supported.
- ADDR_WIDTH_POW, 6, log2 of address width; only 6 supported.
- MEM_DEPTH_POW, 12, log2 of words in the attached data memory; used for the range check.

Ports:
- clk_in  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (size/unsigned)
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-justified
- mem_addr  out  64  word-aligned address to memory
- mem_wdata  out  64  full word to write
- mem_write  out  1  memory write enable
- mem_read  out  1  memory read enable
- mem_rdata  in  64  asynchronous read data from memory
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  64  load result (0 for stores/faults)
- resp_fault  out  1  request was rejected
- resp_cause  out  2  01 misaligned, 10 illegal funct3, 11 out of range, 00 none

Behaviour:
- Accept: a request is accepted when req_valid && req_ready. req_ready=1 only in IDLE. On accept, latch store/funct3/addr/wdata.
- Sizes:
  - funct3[1:0]: 00 B, 01 H, 10 W, 11 D.
  - funct3[2]=1 means zero-extend, loads only.
  - Illegal: load 111; store with funct3[2]=1.
- Fault priority (evaluated at accept): illegal > misaligned > out of range.
  - Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0.
  - Out of range: addr[63:3] ≥ 2^MEM_DEPTH_POW.
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
  - IDLE: on accept, go to RESP if faulted; LOAD if load; WRITE if store D; RMW_READ if store B/H/W.
  - LOAD: mem_read=1. Register the extracted, extended result. Go to RESP.
  - RMW_READ: mem_read=1. Register the merged word: mem_rdata with the target lanes replaced by the low bytes of the latched wdata. Go to WRITE.
  - WRITE: mem_write=1. mem_wdata = latched wdata (D) or merged word. Go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, with resp_data/resp_fault/resp_cause valid. req_ready=0. Go to IDLE.
- Latency, counted from the accept cycle:
  - fault: resp in cycle +1
  - load, store D: cycle +2
  - store B/H/W: cycle +3
  - One request in flight at a time; back-to-back accepts are possible one cycle after RESP.
- Memory interface:
  - mem_addr = {latched addr[63:3], 3'b000} in LOAD/RMW_READ/WRITE, else 0.
  - mem_read and mem_write are never both 1.
  - All mem_* outputs are 0 in IDLE and RESP.
  - No memory access is issued for faulted requests.
- Lanes: little-endian; byte lane k = bits [8k+7:8k]; offset = addr[2:0].
  - Load: B takes lane offset; H takes lanes offset..offset+1; W takes lanes offset..offset+3.
  - Load result is sign-extended unless funct3[2]=1.
  - resp_data is held at 0 except during RESP for loads.
- Reset:
  - State returns to IDLE.
  - All registered outputs go to 0: resp_valid=0, resp_data=0, resp_fault=0, resp_cause=00, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. req_ready=1 the cycle after reset deasserts.
  - Reset mid-operation drops the in-flight request: no response, and no write is issued in or after the reset cycle. A request presented in a reset cycle is not accepted.

Test Plan:
- Mem word 0x10 = 0x8877665544332211. LB addr 0x13 -> resp at +2: data 0x0000000000000044. LH addr 0x16 -> 0xFFFFFFFFFFFF8877. LHU addr 0x16 -> 0x0000000000008877.
- Mem word 0x20 = 0x1111111111111111. SB addr 0x22, wdata 0xAB -> RMW_READ at +1, mem_write at +2 with mem_addr 0x20 and wdata 0x1111111111AB1111, resp at +3 with fault 0.
- SD addr 0x28, wdata 0xDEADBEEFCAFEF00D -> mem_write at +1; a subsequent LD addr 0x28 returns 0xDEADBEEFCAFEF00D.
- Faults, each resp at +1 with mem_read=mem_write=0 throughout:
  - LW addr 0x1 -> fault=1, cause 01.
  - Store funct3 100 -> cause 10.
  - LD addr 0x8000 with MEM_DEPTH_POW=12 -> cause 11.
- Accept SH addr 0x30; assert reset in the RMW_READ cycle -> no mem_write ever issued, no resp_valid, word 0x30 unchanged, req_ready=1 the cycle after reset drops.
- Hold req_valid high over consecutive LD requests -> req_ready low except in IDLE, exactly one resp_valid pulse per accept, every 3 cycles.
